// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the two-requester register-file arbiter:
// default widths, controller state encoding and requester identifiers.
package regfile_arb_pkg;

   // Default register width and address width of the shared register file.
   localparam int DEF_DATA_W = 4;
   localparam int DEF_ADDR_W = 2;

   // Transaction controller states: one grant cycle in IDLE, one register-file
   // access cycle in SERVE, one completion cycle in ACK.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      ACK   = 2'd2
   } state_e;

   // Requester identifiers; also the encoding of the round-robin pointer.
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   // Requester that should be favoured next after a grant to 'winner'.
   function automatic logic other_req(input logic winner);
      return (winner == REQ_A) ? REQ_B : REQ_A;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational from the request
// vector; the priority pointer only moves when the caller accepts a grant.
module rr_arbiter2
   import regfile_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q;
   logic ptr_d;

   // One-hot grant: a lone requester always wins, a tie goes to the pointer.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Pointer moves away from whoever was just granted, so a waiting
   // requester is served within one transaction.
   always_comb begin
      ptr_d = ptr_q;
      if (advance && (grant != 2'b00)) begin
         ptr_d = other_req(grant[1] ? REQ_B : REQ_A);
      end
   end

   // Pointer register; favours A out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= REQ_A;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the single read and single write port of a small register file
// between requesters A and B. Each transaction takes three cycles:
// IDLE (grant and latch), SERVE (register-file access), ACK (completion pulse).
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   // Requester A
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   // Requester B
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   // Register file
   output logic [ADDR_W-1:0] rf_raddr,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_din,
   output logic              rf_wren,
   input  logic [DATA_W-1:0] rf_dout
);

   // Controller state and the latched transaction.
   state_e            state_q;
   logic              op_we_q;
   logic              op_id_q;
   logic [ADDR_W-1:0] op_addr_q;
   logic [DATA_W-1:0] op_wdata_q;

   // Registered outputs.
   logic              rf_wren_q;
   logic              a_ack_q;
   logic              b_ack_q;
   logic [DATA_W-1:0] a_rdata_q;
   logic [DATA_W-1:0] b_rdata_q;

   // Arbitration interface.
   logic [1:0]        grant;
   logic              advance;
   logic              win_b;

   // Selected requester's transaction fields, valid while granting in IDLE.
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Requests are only considered in IDLE; SERVE and ACK ignore them.
   assign advance = (state_q == IDLE);

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({b_req, a_req}),
      .advance (advance),
      .grant   (grant)
   );

   assign win_b = grant[1];

   // Mux the winning requester's operation toward the op register.
   always_comb begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
      if (win_b) begin
         sel_we    = b_we;
         sel_addr  = b_addr;
         sel_wdata = b_wdata;
      end
   end

   // Transaction FSM: grant/latch in IDLE, access in SERVE, ack pulse in ACK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_we_q    <= 1'b0;
         op_id_q    <= REQ_A;
         op_addr_q  <= '0;
         op_wdata_q <= '0;
         rf_wren_q  <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         // Acks are single-cycle pulses unless SERVE raises one below.
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (grant != 2'b00) begin
                  op_we_q    <= sel_we;
                  op_id_q    <= win_b ? REQ_B : REQ_A;
                  op_addr_q  <= sel_addr;
                  op_wdata_q <= sel_wdata;
                  // Write enable is high for exactly the SERVE cycle.
                  rf_wren_q  <= sel_we;
                  state_q    <= SERVE;
               end
            end
            SERVE: begin
               rf_wren_q <= 1'b0;
               if (!op_we_q) begin
                  if (op_id_q == REQ_B) begin
                     b_rdata_q <= rf_dout;
                  end else begin
                     a_rdata_q <= rf_dout;
                  end
               end
               if (op_id_q == REQ_B) begin
                  b_ack_q <= 1'b1;
               end else begin
                  a_ack_q <= 1'b1;
               end
               state_q <= ACK;
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               rf_wren_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   // Read and write address both track the latched address, so the
   // register-file ports see one stable operation for the whole SERVE cycle.
   assign rf_raddr = op_addr_q;
   assign rf_waddr = op_addr_q;
   assign rf_din   = op_wdata_q;
   assign rf_wren  = rf_wren_q;

   assign a_ack   = a_ack_q;
   assign b_ack   = b_ack_q;
   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Testbench for regfile_arbiter: a behavioural register file drives rf_dout,
// and a transaction-level model predicts winner, ack timing and read data.
module tb_regfile_arbiter;
   import regfile_arb_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int AW = DEF_ADDR_W;
   localparam int NE = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_req = 1'b0, b_req = 1'b0;
   logic          a_we = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_ack, b_ack;
   logic [DW-1:0] a_rdata, b_rdata;
   logic [AW-1:0] rf_raddr, rf_waddr;
   logic [DW-1:0] rf_din, rf_dout;
   logic          rf_wren;

   always #5 clk = ~clk;

   regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_req    (a_req),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_ack    (a_ack),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_ack    (b_ack),
      .b_rdata  (b_rdata),
      .rf_raddr (rf_raddr),
      .rf_waddr (rf_waddr),
      .rf_din   (rf_din),
      .rf_wren  (rf_wren),
      .rf_dout  (rf_dout)
   );

   // Environment: the register file itself (combinational read, clocked write).
   logic [DW-1:0] rf_mem [NE];
   assign rf_dout = rf_mem[rf_raddr];
   always @(posedge clk) if (rf_wren) rf_mem[rf_waddr] <= rf_din;

   // Reference model state.
   logic [DW-1:0] model_mem [NE];
   logic [DW-1:0] exp_a_rdata = '0;
   logic [DW-1:0] exp_b_rdata = '0;
   bit            prio_b = 1'b0;
   int            checks = 0;
   int            failures = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
   endtask

   task automatic issue_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
   endtask

   // One full transaction, entered and left at a falling edge of an IDLE cycle.
   // drop: winner withdraws req and scrambles its fields right after the grant.
   // reissue: winner keeps the same request up for a back-to-back transaction.
   task automatic step(input bit drop, input bit reissue);
      bit            wb;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      wb   = (a_req && b_req) ? prio_b : b_req;
      we   = wb ? b_we : a_we;
      addr = wb ? b_addr : a_addr;
      wd   = wb ? b_wdata : a_wdata;
      prio_b = !wb;
      // SERVE cycle
      @(posedge clk); @(negedge clk);
      check("serve_wren", rf_wren, we);
      check("serve_raddr", rf_raddr, addr);
      if (we) begin
         check("serve_waddr", rf_waddr, addr);
         check("serve_din", rf_din, wd);
      end
      check("serve_acks", {a_ack, b_ack}, 2'b00);
      if (drop) begin
         if (wb) begin b_req = 1'b0; b_we = ~b_we; b_addr = ~b_addr; b_wdata = ~b_wdata; end
         else    begin a_req = 1'b0; a_we = ~a_we; a_addr = ~a_addr; a_wdata = ~a_wdata; end
      end
      // ACK cycle
      @(posedge clk); @(negedge clk);
      if (we) model_mem[addr] = wd;
      else if (wb) exp_b_rdata = model_mem[addr];
      else exp_a_rdata = model_mem[addr];
      check("ack_a", a_ack, !wb);
      check("ack_b", b_ack, wb);
      check("ack_wren", rf_wren, 1'b0);
      check("ack_a_rdata", a_rdata, exp_a_rdata);
      check("ack_b_rdata", b_rdata, exp_b_rdata);
      if (!reissue) begin
         if (wb) b_req = 1'b0; else a_req = 1'b0;
      end
      // Back in IDLE
      @(posedge clk); @(negedge clk);
      check("idle_acks", {a_ack, b_ack}, 2'b00);
      check("idle_wren", rf_wren, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < NE; i++) begin
         rf_mem[i]    = '0;
         model_mem[i] = '0;
      end

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_acks", {a_ack, b_ack}, 2'b00);
      check("rst_rdata", {a_rdata, b_rdata}, 8'h00);
      check("rst_rf", {rf_raddr, rf_waddr, rf_din, rf_wren}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: A writes addr 2 = A
      issue_a(1'b1, 2'd2, 4'hA);
      step(1'b0, 1'b0);

      // 2: B reads addr 2
      issue_b(1'b0, 2'd2, 4'h0);
      step(1'b0, 1'b0);
      check("t2_b_rdata", b_rdata, 8'h0A);
      check("t2_a_rdata", a_rdata, 8'h00);

      // 3: both continuously requesting; alternation starts with A
      check("t3_prio_a", prio_b, 1'b0);
      issue_a(1'b1, 2'd1, 4'h3);
      issue_b(1'b0, 2'd1, 4'h0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
      check("t3_b_rdata", b_rdata, 8'h03);
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);

      // 4: write addr 0 = 5, read it back-to-back, then further A writes
      issue_a(1'b1, 2'd0, 4'h5);
      step(1'b0, 1'b0);
      issue_a(1'b0, 2'd0, 4'h0);
      step(1'b0, 1'b0);
      check("t4_a_rdata", a_rdata, 8'h05);
      issue_a(1'b1, 2'd1, 4'h9);
      step(1'b0, 1'b0);
      issue_a(1'b1, 2'd3, 4'h6);
      step(1'b0, 1'b0);
      check("t4_a_rdata_hold", a_rdata, 8'h05);

      // 5: reset in the middle of B's SERVE write of F to addr 3
      issue_b(1'b1, 2'd3, 4'hF);
      @(posedge clk); @(negedge clk);
      check("t5_serve_wren", rf_wren, 1'b1);
      rst_n = 1'b0;
      b_req = 1'b0;
      #1;
      check("t5_wren_async", rf_wren, 1'b0);
      check("t5_rdata_async", {a_rdata, b_rdata}, 8'h00);
      @(posedge clk); @(negedge clk);
      check("t5_no_ack", {a_ack, b_ack}, 2'b00);
      rst_n = 1'b1;
      prio_b = 1'b0;
      exp_a_rdata = '0;
      exp_b_rdata = '0;
      @(posedge clk); @(negedge clk);
      check("t5_no_late_ack", {a_ack, b_ack}, 2'b00);
      issue_a(1'b0, 2'd3, 4'h0);
      step(1'b0, 1'b0);
      check("t5_addr3_kept", a_rdata, 8'h06);

      // 6: A drops req one cycle after grant
      issue_a(1'b1, 2'd2, 4'h7);
      step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         check("t6_no_regrant", {a_ack, b_ack, rf_wren}, 3'b000);
      end

      // Randomized mix of reads, writes and contention
      for (int i = 0; i < 80; i++) begin
         if (!a_req && ($urandom_range(0, 2) != 0))
            issue_a(1'($urandom_range(0, 1)), AW'($urandom_range(0, NE - 1)), DW'($urandom_range(0, 15)));
         if (!b_req && ($urandom_range(0, 2) != 0))
            issue_b(1'($urandom_range(0, 1)), AW'($urandom_range(0, NE - 1)), DW'($urandom_range(0, 15)));
         if (!a_req && !b_req)
            issue_b(1'b0, AW'($urandom_range(0, NE - 1)), '0);
         step(1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single read port and single write port of the 4-entry x 4-bit register file between two requesters, A and B.
- Each requester issues one read or write per transaction over a req/ack handshake.
- Arbitration is round-robin.
- The block sits between the two requesters and the register file, and drives all register-file address, data and write-enable inputs.

Parameters:
- DATA_W, 4, register width; must match the register file data width.
- ADDR_W, 2, register address width; entries = 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A transaction request; held high until a_ack.
- a_we  in  1  A operation: 1 = write, 0 = read; stable while a_req is high.
- a_addr  in  ADDR_W  A register address; stable while a_req is high.
- a_wdata  in  DATA_W  A write data; stable while a_req is high.
- a_ack  out  1  A completion; single-cycle pulse.
- a_rdata  out  DATA_W  A read result; valid from the a_ack cycle and held until the next A read ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same widths and meanings for requester B.
- rf_raddr  out  ADDR_W  register-file read address.
- rf_waddr  out  ADDR_W  register-file write address.
- rf_din  out  DATA_W  register-file write data.
- rf_wren  out  1  register-file write enable.
- rf_dout  in  DATA_W  register-file read data; combinational from rf_raddr.

Behaviour:
- **Reset:** while rst_n = 0, all registered state is cleared immediately, independent of clk:
  - FSM goes to IDLE; priority points to A.
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0.
  - rf_raddr = rf_waddr = 0; rf_din = 0; rf_wren = 0.
  - Register-file contents are not reset.
- **FSM states:** IDLE, SERVE, ACK; one-hot or binary encoding.
- **IDLE:**
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner, latch its we/addr/wdata and ID into the op register, and go to SERVE.
- **Arbitration:**
  - If only one req is high, that requester wins.
  - If both are high, the requester named by the priority pointer wins.
  - On every grant the pointer moves to the other requester.
  - A waiting requester is therefore served within one transaction.
- **SERVE (one cycle):**
  - rf_raddr and rf_waddr both equal the latched addr; rf_din equals the latched wdata.
  - For a write, rf_wren = 1 for exactly this cycle, so the write commits on the edge that ends SERVE.
  - For a read, rf_wren = 0, and rf_dout is captured into the winner's rdata register on the edge that ends SERVE.
  - Next state: ACK.
- **ACK (one cycle):**
  - The winner's ack = 1 (registered output); the other ack stays 0.
  - Both reqs are ignored this cycle.
  - Next state: IDLE.
- **Latency:** ack is asserted 2 cycles after the edge that samples req in IDLE. Throughput is one transaction per 3 cycles.
- **rf_wren** is high only in SERVE with a latched write; it is never high in IDLE or ACK.
- **rdata registers:** a write ack leaves the requester's rdata unchanged; the other requester's rdata is never disturbed.
- **Ordering:** a read issued after a write ack returns the written value (read-after-write through separate transactions).
- **Protocol violation:** if req drops before ack, the latched transaction still completes and ack still pulses. Changes to we/addr/wdata after the IDLE grant edge are ignored.
- **Back-to-back:** a req still high in the IDLE cycle after its ack is treated as a new transaction.
- **Reset mid-transaction:** rst_n falling during SERVE deasserts rf_wren immediately; the pending write or read is aborted and no ack is issued.

Decomposition:
- Package regfile_arb_pkg holds:
  - DATA_W/ADDR_W defaults;
  - FSM state encodings IDLE/SERVE/ACK;
  - requester ID constants REQ_A = 0, REQ_B = 1.
- Sub-module rr_arbiter2: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot grant[1:0].
  - Holds the priority pointer, resets it to A, and is instantiated once.

Test Plan:
1. Reset, then A writes addr 2 = 4'hA -> rf_wren high for exactly 1 cycle with rf_waddr = 2 and rf_din = 4'hA; a_ack pulses 2 cycles after grant; b_ack stays 0.
2. After test 1, B reads addr 2 -> b_rdata = 4'hA in the b_ack cycle; a_rdata unchanged (0); rf_wren stays 0 throughout.
3. Both reqs high continuously (A writes addr 1 = 4'h3, B reads addr 1) -> grants alternate A, B, A, B starting with A; B's first read returns 4'h3; each ack spaced 3 cycles apart.
4. A write ack followed by an A read of addr 0 (written 4'h5 earlier) in the next IDLE -> a_rdata = 4'h5; a_rdata holds its value across intervening writes by A.
5. Assert rst_n = 0 mid-SERVE of a B write of 4'hF to addr 3 -> rf_wren drops immediately; no b_ack; a subsequent read of addr 3 returns its prior value.
6. A drops a_req one cycle after grant -> transaction still completes and a_ack pulses once; no spurious second grant.
